// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the inter-stage pipeline register: skid FSM state
// encodings and default widths.
package pipe_stage_reg_pkg;

  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'b00,
    PIPE_ONE   = 2'b01,
    PIPE_FULL  = 2'b10
  } pipe_state_e;

  localparam int PIPE_DATA_W = 128;
  localparam int PIPE_CNT_W  = 32;

endpackage

// File: rtl/pipe_stage_reg_sat_cnt.sv
// Saturating up-counter used for the pipeline-stage performance counters.
// Holds at all-ones instead of wrapping; cleared only by reset.
module pipe_sat_cnt
  import pipe_stage_reg_pkg::*;
#(
  parameter int CNT_W = PIPE_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   cnt <= '0;
    else if (inc && (~&cnt))    cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline register with valid/ready handshake and a 2-entry skid
// buffer; optional perf counters enabled by `define PIPE_PERF_CNT_EN.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  pipe_state_e       state_q, state_nxt;
  logic [DATA_W-1:0] main_q, main_nxt;
  logic [DATA_W-1:0] skid_q, skid_nxt;
  logic              in_ready_q, in_ready_nxt;
  logic              push, pop;

  assign out_valid = (state_q != PIPE_EMPTY);
  assign in_ready  = in_ready_q;
  assign out_data  = main_q;
  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= PIPE_EMPTY;
    else      state_q <= state_nxt;
  end

  // next-state
  always_comb begin
    state_nxt = state_q;
    if (flush) state_nxt = PIPE_EMPTY;
    else begin
      case (state_q)
        PIPE_EMPTY: if (push) state_nxt = PIPE_ONE;
        PIPE_ONE: begin
          if (push && !pop)      state_nxt = PIPE_FULL;
          else if (!push && pop) state_nxt = PIPE_EMPTY;
        end
        PIPE_FULL:  if (pop) state_nxt = PIPE_ONE;
        default:    state_nxt = PIPE_EMPTY;
      endcase
    end
  end

  // datapath / ready outputs; vacated slots are zeroed so a bubble reads as 0
  always_comb begin
    main_nxt     = main_q;
    skid_nxt     = skid_q;
    in_ready_nxt = (state_nxt != PIPE_FULL);
    if (flush) begin
      main_nxt = '0;
      skid_nxt = '0;
    end else begin
      case (state_q)
        PIPE_EMPTY: if (push) main_nxt = in_data;
        PIPE_ONE: begin
          if (push && pop)  main_nxt = in_data;
          else if (push)    skid_nxt = in_data;
          else if (pop)     main_nxt = '0;
        end
        PIPE_FULL: begin
          if (pop) begin
            main_nxt = skid_q;
            skid_nxt = '0;
          end
        end
        default: begin
          main_nxt = '0;
          skid_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      main_q     <= main_nxt;
      skid_q     <= skid_nxt;
      in_ready_q <= in_ready_nxt;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic stall_inc, bubble_inc;
  assign stall_inc  = out_valid & ~out_ready;
  assign bubble_inc = ~out_valid;

  pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk), .rst (rst), .inc (stall_inc),  .cnt (stall_cnt)
  );
  pipe_sat_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk), .rst (rst), .inc (bubble_inc), .cnt (bubble_cnt)
  );
  pipe_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk), .rst (rst), .inc (flush),      .cnt (flush_cnt)
  );
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed-vector bench for pipe_stage_reg: streaming, backpressure, flush,
// push&pop steady state, async reset and (macro-dependent) perf counters.
module tb_pipe_stage_reg;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] stall_cnt, bubble_cnt, flush_cnt;

  int nvec = 0;
  int nerr = 0;

  pipe_stage_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt),
    .flush_cnt  (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // outputs depend only on flops, so sampling 1 time unit after the edge is safe
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [DW-1:0] d, input logic r);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(v));
    chk({tag, ".out_data"},  64'(out_data),  64'(d));
    chk({tag, ".in_ready"},  64'(in_ready),  64'(r));
  endtask

  initial begin
    logic [DW-1:0] d;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    chk_out("rst0", 1'b0, '0, 1'b1);
    chk("rst0.stall",  64'(stall_cnt),  64'd0);
    chk("rst0.bubble", 64'(bubble_cnt), 64'd0);
    chk("rst0.flush",  64'(flush_cnt),  64'd0);
    rst = 1'b1;

    // streaming at full rate
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = DW'(i);
      tick();
      chk_out($sformatf("stream%0d", i), 1'b1, DW'(i), 1'b1);
    end
    in_valid = 1'b0;
    tick();
    chk_out("stream_end", 1'b0, '0, 1'b1);

    // backpressure into the skid slot
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA;
    tick(); chk_out("bp_a", 1'b1, 32'hA, 1'b1);
    in_data = 32'hB;
    tick(); chk_out("bp_b", 1'b1, 32'hA, 1'b0);
    in_data = 32'hC;
    tick(); chk_out("bp_c_held", 1'b1, 32'hA, 1'b0);
    tick(); chk_out("bp_c_held2", 1'b1, 32'hA, 1'b0);
    out_ready = 1'b1;
    tick(); chk_out("bp_drain_b", 1'b1, 32'hB, 1'b1);
    tick(); chk_out("bp_drain_c", 1'b1, 32'hC, 1'b1);
    in_valid = 1'b0;
    tick(); chk_out("bp_empty", 1'b0, '0, 1'b1);

    // flush while FULL with a push pending
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h1;
    tick();
    in_data = 32'h2;
    tick(); chk_out("fl_full", 1'b1, 32'h1, 1'b0);
    in_data = 32'hD; flush = 1'b1;
    tick(); chk_out("fl_cycle", 1'b0, '0, 1'b1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); chk_out("fl_after", 1'b0, '0, 1'b1);
    tick(); chk_out("fl_after2", 1'b0, '0, 1'b1);

    // steady push&pop in ONE with random payloads
    in_valid = 1'b1; in_data = 32'h1234_5678;
    tick(); chk_out("pp_prime", 1'b1, 32'h1234_5678, 1'b1);
    for (int i = 0; i < 16; i++) begin
      d = DW'($urandom);
      in_data = d;
      tick();
      chk_out($sformatf("pp%0d", i), 1'b1, d, 1'b1);
    end

    // fill to FULL, then asynchronous mid-cycle reset
    out_ready = 1'b0;
    in_data = 32'hE1;
    tick();
    in_data = 32'hE2;
    tick(); chk("pre_rst.in_ready", 64'(in_ready), 64'd0);
    #2 rst = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, '0, 1'b1);
    chk("async_rst.stall",  64'(stall_cnt),  64'd0);
    chk("async_rst.bubble", 64'(bubble_cnt), 64'd0);
    chk("async_rst.flush",  64'(flush_cnt),  64'd0);
    tick();
    chk_out("rst_hold", 1'b0, '0, 1'b1);
    rst = 1'b1;

    // counters: one bubble cycle, then 20 stalled cycles, then one flush
    in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b0;
    tick(); chk_out("cnt_load", 1'b1, 32'h55, 1'b1);
    in_valid = 1'b0;
    repeat (20) tick();
    chk_out("cnt_stalled", 1'b1, 32'h55, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk_out("cnt_flushed", 1'b0, '0, 1'b1);
`ifdef PIPE_PERF_CNT_EN
    chk("cnt.stall_sat", 64'(stall_cnt),  64'd15);
    chk("cnt.bubble",    64'(bubble_cnt), 64'd1);
    chk("cnt.flush",     64'(flush_cnt),  64'd1);
`else
    chk("cnt.stall_off",  64'(stall_cnt),  64'd0);
    chk("cnt.bubble_off", 64'(bubble_cnt), 64'd0);
    chk("cnt.flush_off",  64'(flush_cnt),  64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
